// File: rtl/hellonios_irq_ctrl.sv
// hellonios_irq_ctrl: memory-mapped interrupt aggregator for the Nios II CPU.
// Collects up to 16 peripheral interrupt lines (timer on bit 0), applies
// per-source level/rising-edge capture, enable masking, W1C/ACK clearing and
// a fixed-priority encoder (source 0 highest), and drives one CPU irq line.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   irq_in     peripheral interrupt requests, active-high
//   address    3-bit word address of the 16-bit Avalon-MM slave
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data (one-cycle latency)
//   irq        registered interrupt to the CPU
//
// Register map: 0 PENDING (W1C), 1 ENABLE, 2 EDGE_SEL, 3 ACTIVE (write = ACK),
// 4 RAW, 5-7 read 0.
//
// Optional feature: define HELLONIOS_IRQ_CTRL_SYNC_EN to pass every irq_in bit
// through a 2-flop synchronizer before it is used.
module hellonios_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    localparam int unsigned     DW        = 16;
    // Bits at or above NUM_SRC are never stored, so they read back as 0.
    localparam logic [DW-1:0]   SRC_MASK  = DW'((17'd1 << NUM_SRC) - 17'd1);
    localparam logic [4:0]      NUM_SRC_W = 5'(NUM_SRC);

    logic [DW-1:0] raw;
    logic [DW-1:0] prev_raw;
    logic [DW-1:0] enable_q;
    logic [DW-1:0] edge_sel_q;
    logic [DW-1:0] pend_q;      // stored pending, meaningful for edge sources only
    logic [DW-1:0] pend_next;
    logic [DW-1:0] pending;
    logic [DW-1:0] masked;
    logic [DW-1:0] rise;
    logic [DW-1:0] wd;
    logic [DW-1:0] ack_sel;
    logic          wr_en;
    logic          ack_ok;
    logic          active_valid;
    logic [3:0]    active_id;

`ifdef HELLONIOS_IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    // Two-flop synchronizer per input line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign raw = DW'(sync_q2);
`else
    assign raw = DW'(irq_in);
`endif

    assign wr_en   = chipselect & ~write_n;
    assign wd      = writedata & SRC_MASK;
    assign rise    = raw & ~prev_raw;
    // Level sources follow raw directly; edge sources show the latch.
    assign pending = (pend_q & edge_sel_q) | (raw & ~edge_sel_q);
    assign masked  = pending & enable_q;
    assign active_valid = |masked;
    assign ack_ok  = {1'b0, writedata[3:0]} < NUM_SRC_W;
    assign ack_sel = ack_ok ? (DW'(1) << writedata[3:0]) : '0;

    // Fixed-priority encoder: lowest set index wins.
    always_comb begin
        active_id = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                active_id = 4'(i);
            end
        end
    end

    // Edge latch update: clears first, then a new rise overrides them.
    always_comb begin
        pend_next = pend_q;
        if (wr_en && address == 3'd0) begin
            pend_next = pend_next & ~wd;
        end
        if (wr_en && address == 3'd3) begin
            pend_next = pend_next & ~ack_sel;
        end
        pend_next = pend_next | (rise & edge_sel_q);
        // Sources switched to (or kept at) level mode drop any stored bit.
        if (wr_en && address == 3'd2) begin
            pend_next = pend_next & wd;
        end
    end

    // Control/status registers, edge history and CPU interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q   <= '0;
            edge_sel_q <= '0;
            pend_q     <= '0;
            prev_raw   <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_en && address == 3'd1) begin
                enable_q <= wd;
            end
            if (wr_en && address == 3'd2) begin
                edge_sel_q <= wd;
            end
            pend_q   <= pend_next;
            prev_raw <= raw;
            irq      <= active_valid;
        end
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= pending;
                3'd1:    readdata <= enable_q;
                3'd2:    readdata <= edge_sel_q;
                3'd3:    readdata <= {active_valid, 11'b0, active_id};
                3'd4:    readdata <= raw;
                default: readdata <= 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_hellonios_irq_ctrl.sv
module tb_hellonios_irq_ctrl;

    localparam int unsigned NUM_SRC = 8;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] irq_in;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic               irq;

    hellonios_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Reference model: per-source rules, evaluated once per clock edge.
    logic [15:0]        m_en, m_edge, m_latch, m_prev;
    logic [NUM_SRC-1:0] m_s1, m_s2;
    logic [15:0]        m_rd;
    logic               m_irq;

    task automatic model_reset();
        m_en = '0; m_edge = '0; m_latch = '0; m_prev = '0;
        m_s1 = '0; m_s2 = '0;
    endtask

    task automatic model_edge();
        logic [15:0] raw;
        logic [15:0] pend;
        int          first;
        logic        wr;
`ifdef HELLONIOS_IRQ_CTRL_SYNC_EN
        raw = 16'(m_s2);
`else
        raw = 16'(irq_in);
`endif
        pend = '0;
        for (int i = 0; i < NUM_SRC; i++) pend[i] = m_edge[i] ? m_latch[i] : raw[i];
        m_irq = ((pend & m_en) != 16'h0);
        first = -1;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (pend[i] && m_en[i]) first = i;
        case (address)
            3'd0: m_rd = pend;
            3'd1: m_rd = m_en;
            3'd2: m_rd = m_edge;
            3'd3: m_rd = (first >= 0) ? (16'h8000 | 16'(first)) : 16'h0000;
            3'd4: m_rd = raw;
            default: m_rd = 16'h0000;
        endcase
        wr = chipselect && !write_n;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_edge[i]) begin
                if (wr && address == 3'd0 && writedata[i]) m_latch[i] = 1'b0;
                if (wr && address == 3'd3 && int'(writedata[3:0]) == i) m_latch[i] = 1'b0;
                if (raw[i] && !m_prev[i]) m_latch[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr && address == 3'd1) m_en[i] = writedata[i];
            if (wr && address == 3'd2) begin
                m_edge[i] = writedata[i];
                if (!writedata[i]) m_latch[i] = 1'b0;
            end
        end
        m_prev = raw;
        m_s2   = m_s1;
        m_s1   = irq_in;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_SRC-1:0] in, input logic [2:0] a,
                         input logic wr, input logic [15:0] d);
        irq_in     = in;
        address    = a;
        chipselect = wr;
        write_n    = !wr;
        writedata  = d;
    endtask

    typedef struct {
        logic [NUM_SRC-1:0] irq_in;
        logic [2:0]         addr;
        logic               wr;
        logic [15:0]        wd;
        logic [15:0]        exp_rd;
        logic               exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [NUM_SRC-1:0] in, input logic [2:0] a, input logic wr,
                       input logic [15:0] d, input logic [15:0] er, input logic ei);
        vec_t v;
        v.irq_in = in; v.addr = a; v.wr = wr; v.wd = d; v.exp_rd = er; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        drive('0, 3'd0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 16'h0000);
        check("reset_irq", 16'(irq), 16'h0000);
        reset = 1'b0;
        model_reset();

`ifndef HELLONIOS_IRQ_CTRL_SYNC_EN
        // Each row: one clock; readdata reflects the pre-edge state.
        add(8'h01, 3'd4, 0, 16'h0000, 16'h0001, 0);  // RAW
        add(8'h01, 3'd0, 0, 16'h0000, 16'h0001, 0);  // level pending, masked off
        add(8'h01, 3'd1, 1, 16'h0001, 16'h0000, 0);  // ENABLE=1
        add(8'h01, 3'd3, 0, 16'h0000, 16'h8000, 1);
        add(8'h00, 3'd0, 0, 16'h0000, 16'h0000, 0);  // level drops
        add(8'h01, 3'd0, 1, 16'h0001, 16'h0001, 1);  // W1C on level source
        add(8'h01, 3'd0, 0, 16'h0000, 16'h0001, 1);
        add(8'h00, 3'd1, 1, 16'h0008, 16'h0001, 0);
        add(8'h00, 3'd2, 1, 16'h0008, 16'h0000, 0);  // source 3 edge
        add(8'h08, 3'd0, 0, 16'h0000, 16'h0000, 0);  // 1-cycle pulse
        add(8'h00, 3'd0, 0, 16'h0000, 16'h0008, 1);
        add(8'h00, 3'd3, 0, 16'h0000, 16'h8003, 1);
        add(8'h00, 3'd3, 1, 16'h0003, 16'h8003, 1);  // ACK 3
        add(8'h00, 3'd0, 0, 16'h0000, 16'h0000, 0);
        add(8'h00, 3'd1, 1, 16'h0024, 16'h0008, 0);
        add(8'h00, 3'd2, 1, 16'h0004, 16'h0008, 0);
        add(8'h24, 3'd3, 0, 16'h0000, 16'h8005, 1);  // 5 level, 2 rising
        add(8'h24, 3'd3, 0, 16'h0000, 16'h8002, 1);
        add(8'h24, 3'd3, 1, 16'h0002, 16'h8002, 1);  // ACK 2
        add(8'h24, 3'd3, 0, 16'h0000, 16'h8005, 1);
        add(8'h20, 3'd0, 0, 16'h0000, 16'h0020, 1);
        add(8'h24, 3'd0, 0, 16'h0000, 16'h0020, 1);  // new rise on 2
        add(8'h24, 3'd3, 1, 16'h000C, 16'h8002, 1);  // ACK 12: out of range
        add(8'h24, 3'd0, 0, 16'h0000, 16'h0024, 1);
        add(8'h24, 3'd2, 1, 16'h000C, 16'h0004, 1);
        add(8'h2C, 3'd0, 1, 16'h0008, 16'h0024, 1);  // W1C 3 with rise on 3
        add(8'h2C, 3'd0, 0, 16'h0000, 16'h002C, 1);
        add(8'h2C, 3'd0, 1, 16'h0024, 16'h002C, 1);
        add(8'h2C, 3'd0, 0, 16'h0000, 16'h0028, 1);
        add(8'h24, 3'd2, 1, 16'h0004, 16'h000C, 1);  // 3 back to level
        add(8'h24, 3'd0, 0, 16'h0000, 16'h0020, 1);
        add(8'h24, 3'd2, 1, 16'h000C, 16'h0004, 1);
        add(8'h24, 3'd0, 0, 16'h0000, 16'h0020, 1);  // latch of 3 was cleared
        add(8'hA5, 3'd4, 0, 16'h0000, 16'h00A5, 1);
        add(8'hA5, 3'd5, 0, 16'h0000, 16'h0000, 1);
        add(8'hA5, 3'd1, 1, 16'hFF00, 16'h0024, 1);  // upper bits ignored
        add(8'hA5, 3'd1, 0, 16'h0000, 16'h0000, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].irq_in, tbl[k].addr, tbl[k].wr, tbl[k].wd);
            step();
            check($sformatf("vec%0d_readdata", k), readdata, tbl[k].exp_rd);
            check($sformatf("vec%0d_irq", k), 16'(irq), 16'(tbl[k].exp_irq));
        end
`else
        // Synchronizer latency: input changes just after edge E0, irq at E3.
        drive('0, 3'd1, 1'b1, 16'h0002);
        step();
        drive('0, 3'd0, 1'b0, 16'h0);
        repeat (2) step();
        drive(8'h02, 3'd0, 1'b0, 16'h0);
        step();
        check("sync_e1_irq", 16'(irq), 16'h0000);
        step();
        check("sync_e2_irq", 16'(irq), 16'h0000);
        step();
        check("sync_e3_irq", 16'(irq), 16'h0001);
`endif

        // Reset asserted while an interrupt is pending.
        drive(8'h01, 3'd1, 1'b1, 16'h0001);
        step();
        drive(8'h01, 3'd0, 1'b0, 16'h0);
        repeat (4) step();
        check("pre_reset_irq", 16'(irq), 16'h0001);
        check("pre_reset_readdata", readdata, 16'h0001);
        #3 reset = 1'b1;
        #1;
        check("async_reset_irq", 16'(irq), 16'h0000);
        check("async_reset_readdata", readdata, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
`ifndef HELLONIOS_IRQ_CTRL_SYNC_EN
        check("post_reset_level_pending", readdata, 16'h0001);
`else
        check("post_reset_sync_pending", readdata, 16'h0000);
`endif
        check("post_reset_irq", 16'(irq), 16'h0000);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            irq_in     = irq_in ^ NUM_SRC'($urandom & $urandom);
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = (address == 3'd3) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            step();
            check($sformatf("rand%0d_readdata", n), readdata, m_rd);
            check($sformatf("rand%0d_irq", n), 16'(irq), 16'(m_irq));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
